// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Holds the state enum, datapath select encodings, opcode/funct constants,
// cause codes, the packed control bundle and the instruction decoder.
package cu_pkg;

  typedef enum logic [5:0] {
    S_FETCH   = 6'd0,
    S_F_WAIT  = 6'd1,
    S_IR_WR   = 6'd2,
    S_DECODE  = 6'd3,
    S_R_EXEC  = 6'd4,
    S_R_WB    = 6'd5,
    S_ADDR    = 6'd6,
    S_LD_WAIT = 6'd7,
    S_LD_MDR  = 6'd8,
    S_LD_WB   = 6'd9,
    S_ST      = 6'd10,
    S_BEQ     = 6'd11,
    S_BNE     = 6'd12,
    S_LUI     = 6'd13,
    S_JUMP    = 6'd14,
    S_JR      = 6'd15,
    S_RTE     = 6'd16,
    S_NOP     = 6'd17,
    S_BREAK   = 6'd18,
    S_EXC_OP  = 6'd19,
    S_EXC_OVF = 6'd20,
    S_EXC_IRQ = 6'd21,
    S_X_WAIT  = 6'd22,
    S_X_MDR   = 6'd23,
    S_X_JMP   = 6'd24
  } state_t;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_FUNCT  = 3'b010;
  localparam logic [2:0] ALU_PASS_A = 3'b011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EPC    = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_LUI    = 2'b10;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;
  localparam logic [1:0] IORD_VEC    = 2'b10;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_A   = 2'b01;
  localparam logic [1:0] SRCA_MDR = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_RTE   = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_NOP   = 6'h00;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_BREAK = 6'h0D;
  localparam logic [5:0] F_RTE   = 6'h10;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_XOR   = 6'h26;

  localparam logic [1:0] CAUSE_OP  = 2'b00;
  localparam logic [1:0] CAUSE_OVF = 2'b01;
  localparam logic [1:0] CAUSE_IRQ = 2'b10;

  typedef struct packed {
    logic       mem_write;
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       reg_dst;
    logic       reg_write;
    logic       ir_write;
    logic       mdr_write;
    logic       aluout_write;
    logic       epc_write;
    logic       cause_write;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [1:0] iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] int_cause;
    logic       halted;
  } ctrl_t;

  // Next state out of DECODE; anything unrecognised is an opcode exception.
  function automatic state_t decode_instr(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = S_EXC_OP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_XOR: s = S_R_EXEC;
          F_NOP:   s = S_NOP;
          F_JR:    s = S_JR;
          F_BREAK: s = S_BREAK;
          default: s = S_EXC_OP;
        endcase
      end
      OP_RTE:  s = (fn == F_RTE) ? S_RTE : S_EXC_OP;
      OP_J:    s = S_JUMP;
      OP_BEQ:  s = S_BEQ;
      OP_BNE:  s = S_BNE;
      OP_LUI:  s = S_LUI;
      OP_LW, OP_SW: s = S_ADDR;
      default: s = S_EXC_OP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_p_wait_counter.sv
// cu_wait_counter: memory wait-state down-counter.
// Ports: i_clock, i_reset (async, active-low), i_load/i_load_val (preset),
//        i_dec (count down, saturates at 0), o_done (count <= 1).
module cu_wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // The wait state is left on the cycle the count reads 1, so the total
  // number of wait cycles equals the preset value.
  assign o_done = (r_count <= W'(1));

endmodule

// File: rtl/multicycle_control_unit_p.sv
// Multicycle MIPS-subset control FSM with parametrised memory latency,
// overflow trap and maskable interrupt.
// Ports: i_clock, i_reset (async, active-low), i_opcode/i_funct (IR fields),
//        i_alu_overflow, i_irq; o_* datapath enables and mux selects,
//        o_int_cause, o_in_handler, o_halted, o_state (debug).
//
// state     | meaning
// FETCH     | PC to memory, PC <= PC+4, preset wait counter
// F_WAIT    | instruction memory wait states
// IR_WR     | latch IR, precompute branch target
// DECODE    | dispatch on opcode/funct
// R_EXEC    | R-type ALU op, overflow check
// R_WB      | write rd
// ADDR      | load/store address, preset wait counter
// LD_WAIT   | data memory wait states
// LD_MDR    | latch MDR
// LD_WB     | write rt from MDR
// ST        | memory write
// BEQ/BNE   | conditional PC update
// LUI       | write immediate
// JUMP/JR   | unconditional PC update
// RTE       | PC <= EPC, leave handler
// NOP       | idle cycle
// BREAK     | halted until reset
// EXC_*     | save EPC and cause
// X_WAIT    | vector fetch wait states
// X_MDR     | latch handler address
// X_JMP     | PC <= handler address
module multicycle_control_unit_p
  import cu_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter bit          OVF_TRAP = 1'b1,
  parameter bit          IRQ_EN   = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_alu_overflow,
  input  logic       i_irq,
  output logic       o_mem_write,
  output logic       o_pc_write,
  output logic       o_pc_write_eq,
  output logic       o_pc_write_ne,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_ir_write,
  output logic       o_mdr_write,
  output logic       o_aluout_write,
  output logic       o_epc_write,
  output logic       o_cause_write,
  output logic [1:0] o_pc_src,
  output logic [1:0] o_mem_to_reg,
  output logic [1:0] o_iord,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_int_cause,
  output logic       o_in_handler,
  output logic       o_halted,
  output logic [5:0] o_state
);

  if (MEM_WAIT > 7) begin : g_bad_mem_wait
    $error("MEM_WAIT must be in the range 0..7");
  end

  localparam logic [2:0] LP_MEM_WAIT = MEM_WAIT[2:0];
  localparam bit         LP_NO_WAIT  = (MEM_WAIT == 0);

  state_t r_state;
  logic   r_in_handler;
  logic   w_cnt_load;
  logic   w_cnt_dec;
  logic   w_cnt_done;
  logic   w_irq_take;
  logic   w_irq_rte;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  assign w_cnt_load = (r_state == S_FETCH) || (r_state == S_ADDR) ||
                      (r_state == S_EXC_OP) || (r_state == S_EXC_OVF) ||
                      (r_state == S_EXC_IRQ);
  assign w_cnt_dec  = (r_state == S_F_WAIT) || (r_state == S_LD_WAIT) ||
                      (r_state == S_X_WAIT);

  cu_wait_counter #(.W(3)) u_wait (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (LP_MEM_WAIT),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

  // RTE drops the mask in the same cycle, so a pending irq is taken right away.
  assign w_irq_take = IRQ_EN && i_irq && !r_in_handler;
  assign w_irq_rte  = IRQ_EN && i_irq;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_FETCH;
      r_in_handler <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= LP_NO_WAIT ? S_IR_WR : S_F_WAIT;
        S_F_WAIT:  if (w_cnt_done) r_state <= S_IR_WR;
        S_IR_WR:   r_state <= S_DECODE;
        S_DECODE:  r_state <= decode_instr(i_opcode, i_funct);
        S_R_EXEC: begin
          if (OVF_TRAP && ((i_funct == F_ADD) || (i_funct == F_SUB)) && i_alu_overflow)
            r_state <= S_EXC_OVF;
          else
            r_state <= S_R_WB;
        end
        S_ADDR: begin
          if (i_opcode == OP_LW) r_state <= LP_NO_WAIT ? S_LD_MDR : S_LD_WAIT;
          else                   r_state <= S_ST;
        end
        S_LD_WAIT: if (w_cnt_done) r_state <= S_LD_MDR;
        S_LD_MDR:  r_state <= S_LD_WB;
        S_R_WB, S_LD_WB, S_ST, S_BEQ, S_BNE, S_LUI, S_JUMP, S_JR, S_NOP:
          r_state <= w_irq_take ? S_EXC_IRQ : S_FETCH;
        S_RTE: begin
          r_in_handler <= 1'b0;
          r_state      <= w_irq_rte ? S_EXC_IRQ : S_FETCH;
        end
        S_BREAK:   r_state <= S_BREAK;
        S_EXC_OP, S_EXC_OVF, S_EXC_IRQ: begin
          r_in_handler <= 1'b1;
          r_state      <= LP_NO_WAIT ? S_X_MDR : S_X_WAIT;
        end
        S_X_WAIT:  if (w_cnt_done) r_state <= S_X_MDR;
        S_X_MDR:   r_state <= S_X_JMP;
        S_X_JMP:   r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.iord      = IORD_PC;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.alu_src_b = SRCB_4;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_IR_WR: begin
        w_ctrl.ir_write     = 1'b1;
        w_ctrl.alu_src_b    = SRCB_BOFF;
        w_ctrl.aluout_write = 1'b1;
      end
      S_R_EXEC: begin
        w_ctrl.alu_src_a    = SRCA_A;
        w_ctrl.alu_op       = ALU_FUNCT;
        w_ctrl.aluout_write = 1'b1;
      end
      S_R_WB: begin
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_ADDR: begin
        w_ctrl.alu_src_a    = SRCA_A;
        w_ctrl.alu_src_b    = SRCB_IMM;
        w_ctrl.aluout_write = 1'b1;
      end
      S_LD_WAIT: w_ctrl.iord = IORD_ALUOUT;
      S_LD_MDR: begin
        w_ctrl.iord      = IORD_ALUOUT;
        w_ctrl.mdr_write = 1'b1;
      end
      S_LD_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = M2R_MDR;
      end
      S_ST: begin
        w_ctrl.iord      = IORD_ALUOUT;
        w_ctrl.mem_write = 1'b1;
      end
      S_BEQ, S_BNE: begin
        w_ctrl.alu_src_a   = SRCA_A;
        w_ctrl.alu_op      = ALU_SUB;
        w_ctrl.pc_src      = PC_ALUOUT;
        w_ctrl.pc_write_eq = (r_state == S_BEQ);
        w_ctrl.pc_write_ne = (r_state == S_BNE);
      end
      S_LUI: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = M2R_LUI;
      end
      S_JUMP: begin
        w_ctrl.pc_src   = PC_JUMP;
        w_ctrl.pc_write = 1'b1;
      end
      S_JR: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_op    = ALU_PASS_A;
        w_ctrl.pc_src    = PC_ALU;
        w_ctrl.pc_write  = 1'b1;
      end
      S_RTE: begin
        w_ctrl.pc_src   = PC_EPC;
        w_ctrl.pc_write = 1'b1;
      end
      S_BREAK: w_ctrl.halted = 1'b1;
      // PC already advanced past the faulting instruction: EPC = PC - 4.
      S_EXC_OP, S_EXC_OVF: begin
        w_ctrl.epc_write   = 1'b1;
        w_ctrl.cause_write = 1'b1;
        w_ctrl.alu_src_b   = SRCB_4;
        w_ctrl.alu_op      = ALU_SUB;
        w_ctrl.int_cause   = (r_state == S_EXC_OP) ? CAUSE_OP : CAUSE_OVF;
      end
      // Interrupt resumes at the next instruction: EPC = PC.
      S_EXC_IRQ: begin
        w_ctrl.epc_write   = 1'b1;
        w_ctrl.cause_write = 1'b1;
        w_ctrl.alu_src_a   = SRCA_PC;
        w_ctrl.alu_op      = ALU_PASS_A;
        w_ctrl.int_cause   = CAUSE_IRQ;
      end
      S_X_WAIT: w_ctrl.iord = IORD_VEC;
      S_X_MDR: begin
        w_ctrl.iord      = IORD_VEC;
        w_ctrl.mdr_write = 1'b1;
      end
      S_X_JMP: begin
        w_ctrl.alu_src_a = SRCA_MDR;
        w_ctrl.alu_op    = ALU_PASS_A;
        w_ctrl.pc_src    = PC_ALU;
        w_ctrl.pc_write  = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // State sits at FETCH during reset; holding the bundle low keeps the
  // datapath from being written until reset is released.
  assign w_out = i_reset ? w_ctrl : '0;

  assign o_mem_write    = w_out.mem_write;
  assign o_pc_write     = w_out.pc_write;
  assign o_pc_write_eq  = w_out.pc_write_eq;
  assign o_pc_write_ne  = w_out.pc_write_ne;
  assign o_reg_dst      = w_out.reg_dst;
  assign o_reg_write    = w_out.reg_write;
  assign o_ir_write     = w_out.ir_write;
  assign o_mdr_write    = w_out.mdr_write;
  assign o_aluout_write = w_out.aluout_write;
  assign o_epc_write    = w_out.epc_write;
  assign o_cause_write  = w_out.cause_write;
  assign o_pc_src       = w_out.pc_src;
  assign o_mem_to_reg   = w_out.mem_to_reg;
  assign o_iord         = w_out.iord;
  assign o_alu_src_a    = w_out.alu_src_a;
  assign o_alu_src_b    = w_out.alu_src_b;
  assign o_alu_op       = w_out.alu_op;
  assign o_int_cause    = w_out.int_cause;
  assign o_halted       = w_out.halted;
  assign o_in_handler   = r_in_handler;
  assign o_state        = r_state;

endmodule

// File: tb/tb_multicycle_control_unit_p.sv
// Directed bench: three instances with MEM_WAIT = 1, 3 and 0.
module tb_multicycle_control_unit_p;

  localparam logic [5:0] S_FETCH = 6'd0,  S_F_WAIT = 6'd1,  S_IR_WR = 6'd2,
                         S_DECODE = 6'd3, S_R_EXEC = 6'd4,  S_R_WB = 6'd5,
                         S_ADDR = 6'd6,   S_LD_WAIT = 6'd7, S_LD_MDR = 6'd8,
                         S_LD_WB = 6'd9,  S_ST = 6'd10,     S_BEQ = 6'd11,
                         S_BNE = 6'd12,   S_LUI = 6'd13,    S_JUMP = 6'd14,
                         S_JR = 6'd15,    S_RTE = 6'd16,    S_NOP = 6'd17,
                         S_BREAK = 6'd18, S_EXC_OP = 6'd19, S_EXC_OVF = 6'd20,
                         S_EXC_IRQ = 6'd21, S_X_WAIT = 6'd22, S_X_MDR = 6'd23,
                         S_X_JMP = 6'd24;

  // enable bits: {mem_write, pc_write, pc_write_eq, pc_write_ne, reg_dst,
  //               reg_write, ir_write, mdr_write, aluout_write, epc_write, cause_write}
  localparam logic [10:0] E_MEMW = 11'h400, E_PCW = 11'h200, E_PCEQ = 11'h100,
                          E_PCNE = 11'h080, E_RDST = 11'h040, E_RW = 11'h020,
                          E_IRW = 11'h010,  E_MDRW = 11'h008, E_AOW = 11'h004,
                          E_EPCW = 11'h002, E_CAUSEW = 11'h001;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [5:0]  opcode, funct;
  logic        ovf, irq;
  logic [10:0] en  [3];
  logic [14:0] sel [3];   // {pc_src, mem_to_reg, iord, alu_src_a, alu_src_b, alu_op, int_cause}
  logic [5:0]  st  [3];
  logic        inh [3];
  logic        hlt [3];
  int          n_cmp, n_bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control_unit_p #(
      .MEM_WAIT ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
      .OVF_TRAP (1'b1),
      .IRQ_EN   (1'b1)
    ) u_dut (
      .i_clock        (clk),
      .i_reset        (rst_n[g]),
      .i_opcode       (opcode),
      .i_funct        (funct),
      .i_alu_overflow (ovf),
      .i_irq          (irq),
      .o_mem_write    (en[g][10]),
      .o_pc_write     (en[g][9]),
      .o_pc_write_eq  (en[g][8]),
      .o_pc_write_ne  (en[g][7]),
      .o_reg_dst      (en[g][6]),
      .o_reg_write    (en[g][5]),
      .o_ir_write     (en[g][4]),
      .o_mdr_write    (en[g][3]),
      .o_aluout_write (en[g][2]),
      .o_epc_write    (en[g][1]),
      .o_cause_write  (en[g][0]),
      .o_pc_src       (sel[g][14:13]),
      .o_mem_to_reg   (sel[g][12:11]),
      .o_iord         (sel[g][10:9]),
      .o_alu_src_a    (sel[g][8:7]),
      .o_alu_src_b    (sel[g][6:5]),
      .o_alu_op       (sel[g][4:2]),
      .o_int_cause    (sel[g][1:0]),
      .o_in_handler   (inh[g]),
      .o_halted       (hlt[g]),
      .o_state        (st[g])
    );
  end

  function automatic logic [10:0] exp_en(input logic [5:0] s);
    case (s)
      S_FETCH, S_JUMP, S_JR, S_RTE, S_X_JMP: return E_PCW;
      S_IR_WR:                     return E_IRW | E_AOW;
      S_R_EXEC, S_ADDR:            return E_AOW;
      S_R_WB:                      return E_RDST | E_RW;
      S_LD_MDR, S_X_MDR:           return E_MDRW;
      S_LD_WB, S_LUI:              return E_RW;
      S_ST:                        return E_MEMW;
      S_BEQ:                       return E_PCEQ;
      S_BNE:                       return E_PCNE;
      S_EXC_OP, S_EXC_OVF, S_EXC_IRQ: return E_EPCW | E_CAUSEW;
      default:                     return 11'h000;
    endcase
  endfunction

  function automatic logic [14:0] mk(input logic [1:0] pc, m2r, io, a, b,
                                     input logic [2:0] op, input logic [1:0] c);
    return {pc, m2r, io, a, b, op, c};
  endfunction

  function automatic logic [14:0] exp_sel(input logic [5:0] s);
    case (s)
      S_FETCH:              return mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0, 2'd0);
      S_IR_WR:              return mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 3'd0, 2'd0);
      S_R_EXEC:             return mk(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd2, 2'd0);
      S_ADDR:               return mk(2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd0);
      S_LD_WAIT, S_LD_MDR, S_ST: return mk(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0);
      S_LD_WB:              return mk(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0);
      S_BEQ, S_BNE:         return mk(2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 3'd1, 2'd0);
      S_LUI:                return mk(2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0);
      S_JUMP:               return mk(2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0);
      S_JR:                 return mk(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd3, 2'd0);
      S_RTE:                return mk(2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0);
      S_EXC_OP:             return mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd1, 2'd0);
      S_EXC_OVF:            return mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd1, 2'd1);
      S_EXC_IRQ:            return mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd3, 2'd2);
      S_X_WAIT, S_X_MDR:    return mk(2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 3'd0, 2'd0);
      S_X_JMP:              return mk(2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 3'd3, 2'd0);
      default:              return 15'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic now(input int d, input logic [5:0] s, input string tag);
    chk({tag, ".state"}, 32'(st[d]), 32'(s));
    chk({tag, ".en"},    32'({hlt[d], en[d]}), 32'({(s == S_BREAK), exp_en(s)}));
    chk({tag, ".sel"},   32'(sel[d]), 32'(exp_sel(s)));
  endtask

  task automatic cyc(input int d, input logic [5:0] s, input string tag);
    @(negedge clk);
    now(d, s, tag);
  endtask

  // Fetch/decode front end, starting at a negedge where the DUT is in FETCH.
  task automatic front(input int d, input int nwait, input string tag);
    now(d, S_FETCH, tag);
    repeat (nwait) cyc(d, S_F_WAIT, tag);
    cyc(d, S_IR_WR, tag);
    cyc(d, S_DECODE, tag);
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, ".state"}, 32'(st[d]), 32'(S_FETCH));
    chk({tag, ".en"},    32'({hlt[d], en[d]}), 32'h0);
    chk({tag, ".sel"},   32'(sel[d]), 32'h0);
    chk({tag, ".inh"},   32'(inh[d]), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 3'b000; opcode = 6'h00; funct = 6'h00; ovf = 1'b0; irq = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset(d, $sformatf("reset%0d", d));

    // ADD, MEM_WAIT=1
    funct = 6'h20;
    rst_n[0] = 1'b1; #1;
    front(0, 1, "add");
    cyc(0, S_R_EXEC, "add");
    cyc(0, S_R_WB, "add");
    cyc(0, S_FETCH, "add");

    // ADD with overflow -> EXC_OVF, no register write
    ovf = 1'b1;
    front(0, 1, "ovf");
    cyc(0, S_R_EXEC, "ovf");
    cyc(0, S_EXC_OVF, "ovf");
    chk("ovf.inh_entry", 32'(inh[0]), 32'h0);
    cyc(0, S_X_WAIT, "ovf");
    chk("ovf.inh_set", 32'(inh[0]), 32'h1);
    cyc(0, S_X_MDR, "ovf");
    cyc(0, S_X_JMP, "ovf");
    cyc(0, S_FETCH, "ovf");
    ovf = 1'b0;

    // RTE leaves the handler
    opcode = 6'h10; funct = 6'h10;
    front(0, 1, "rte");
    cyc(0, S_RTE, "rte");
    chk("rte.inh_during", 32'(inh[0]), 32'h1);
    cyc(0, S_FETCH, "rte");
    chk("rte.inh_after", 32'(inh[0]), 32'h0);

    // irq during BEQ -> EXC_IRQ
    opcode = 6'h04; funct = 6'h00; irq = 1'b1;
    front(0, 1, "beq_irq");
    cyc(0, S_BEQ, "beq_irq");
    cyc(0, S_EXC_IRQ, "beq_irq");
    cyc(0, S_X_WAIT, "beq_irq");
    chk("beq_irq.inh", 32'(inh[0]), 32'h1);
    cyc(0, S_X_MDR, "beq_irq");
    cyc(0, S_X_JMP, "beq_irq");
    cyc(0, S_FETCH, "beq_irq");

    // irq still high inside the handler: masked after NOP
    opcode = 6'h00; funct = 6'h00;
    front(0, 1, "nop_mask");
    cyc(0, S_NOP, "nop_mask");
    cyc(0, S_FETCH, "nop_mask");

    // RTE with irq pending -> taken immediately
    opcode = 6'h10; funct = 6'h10;
    front(0, 1, "rte_irq");
    cyc(0, S_RTE, "rte_irq");
    cyc(0, S_EXC_IRQ, "rte_irq");
    irq = 1'b0;
    cyc(0, S_X_WAIT, "rte_irq");
    cyc(0, S_X_MDR, "rte_irq");
    cyc(0, S_X_JMP, "rte_irq");
    cyc(0, S_FETCH, "rte_irq");

    // Bad opcode
    opcode = 6'h3F;
    front(0, 1, "badop");
    cyc(0, S_EXC_OP, "badop");
    cyc(0, S_X_WAIT, "badop");
    cyc(0, S_X_MDR, "badop");
    cyc(0, S_X_JMP, "badop");
    cyc(0, S_FETCH, "badop");

    // BREAK holds for 20 cycles, irq ignored there
    opcode = 6'h00; funct = 6'h0D;
    front(0, 1, "brk");
    cyc(0, S_BREAK, "brk");
    irq = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, S_BREAK, $sformatf("brk%0d", i));
    irq = 1'b0;
    #2 rst_n[0] = 1'b0; #1;
    chk_reset(0, "brk_rst");

    // LW, MEM_WAIT=3: 12 cycles
    opcode = 6'h23; funct = 6'h00;
    @(negedge clk);
    rst_n[1] = 1'b1; #1;
    front(1, 3, "lw3");
    cyc(1, S_ADDR, "lw3");
    repeat (3) cyc(1, S_LD_WAIT, "lw3");
    cyc(1, S_LD_MDR, "lw3");
    cyc(1, S_LD_WB, "lw3");
    cyc(1, S_FETCH, "lw3");

    // Reset mid-LD_WAIT
    front(1, 3, "lw3r");
    cyc(1, S_ADDR, "lw3r");
    cyc(1, S_LD_WAIT, "lw3r");
    #2 rst_n[1] = 1'b0; #1;
    chk_reset(1, "lw3_rst");

    // MEM_WAIT=0: no wait states anywhere
    opcode = 6'h2B;
    @(negedge clk);
    rst_n[2] = 1'b1; #1;
    front(2, 0, "sw0");
    cyc(2, S_ADDR, "sw0");
    cyc(2, S_ST, "sw0");
    cyc(2, S_FETCH, "sw0");

    opcode = 6'h23;
    front(2, 0, "lw0");
    cyc(2, S_ADDR, "lw0");
    cyc(2, S_LD_MDR, "lw0");
    cyc(2, S_LD_WB, "lw0");
    cyc(2, S_FETCH, "lw0");

    opcode = 6'h0F;
    front(2, 0, "lui");
    cyc(2, S_LUI, "lui");
    cyc(2, S_FETCH, "lui");

    opcode = 6'h02;
    front(2, 0, "jump");
    cyc(2, S_JUMP, "jump");
    cyc(2, S_FETCH, "jump");

    opcode = 6'h00; funct = 6'h08;
    front(2, 0, "jr");
    cyc(2, S_JR, "jr");
    cyc(2, S_FETCH, "jr");

    opcode = 6'h05; funct = 6'h00;
    front(2, 0, "bne");
    cyc(2, S_BNE, "bne");
    cyc(2, S_FETCH, "bne");

    // ADDU overflow does not trap
    opcode = 6'h00; funct = 6'h21; ovf = 1'b1;
    front(2, 0, "addu_ovf");
    cyc(2, S_R_EXEC, "addu_ovf");
    cyc(2, S_R_WB, "addu_ovf");
    cyc(2, S_FETCH, "addu_ovf");

    // SUB overflow traps, vector fetch without wait states
    funct = 6'h22;
    front(2, 0, "sub_ovf");
    cyc(2, S_R_EXEC, "sub_ovf");
    cyc(2, S_EXC_OVF, "sub_ovf");
    cyc(2, S_X_MDR, "sub_ovf");
    cyc(2, S_X_JMP, "sub_ovf");
    cyc(2, S_FETCH, "sub_ovf");
    chk("sub_ovf.inh", 32'(inh[2]), 32'h1);
    ovf = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
